sprite_draw_sequencer: RTL and testbench
========================================

Name: sprite_draw_sequencer

Overview:
- Initiator side of the shape-draw handshake. It queues sprite draw requests and presents each one to the downstream 60x60 shape-drawing FSM: origin, ROM start address, then a start strobe.
- It then waits for that FSM to go busy and return to done before issuing the next request.
- Sits between game logic (note/track scheduler) and the shape drawer that feeds the VGA adapter.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of 2, >=2)
- SPRITE_BITS, 2, width of sprite index
- SPRITE_WORDS, 3600, ROM words per sprite (60x60); SPRITE_WORDS*2^SPRITE_BITS <= 32768
- ACK_TIMEOUT, 8, max cycles after start strobe for shape_done to drop

Ports:
- clock, input, 1, system clock, all state on rising edge
- resetn, input, 1, asynchronous active-low reset
- req_valid, input, 1, draw request present
- req_ready, output, 1, queue can accept (= not full)
- req_x, input, 8, sprite origin x
- req_y, input, 7, sprite origin y
- req_sprite, input, SPRITE_BITS, sprite index
- draw_x, output, 8, origin x presented to drawer
- draw_y, output, 7, origin y presented to drawer
- start_address, output, 15, sprite ROM base = req_sprite*SPRITE_WORDS
- start, output, 1, one-cycle startingAddressLoaded pulse to drawer
- shape_done, input, 1, drawer idle/done level (high when drawer idle)
- busy, output, 1, high in any state except IDLE
- err_timeout, output, 1, sticky; drawer failed to acknowledge start
- shapes_drawn, output, 8, completed draws, wraps 255->0

Behaviour:
- Reset (resetn low, async): state IDLE, FIFO empty, draw_x/draw_y/start_address/shapes_drawn = 0, start = 0, busy = 0, err_timeout = 0. req_ready = 1 once the FIFO is empty. Reset mid-draw abandons the request and clears the queue.
- Enqueue: req_valid && req_ready on a clock edge. Requests with req_ready = 0 are dropped, not stalled.
- req_ready is derived from full only; a push while full is rejected even if a pop happens in the same cycle.
- No bypass: a request pushed into an empty FIFO is poppable the following cycle.
- FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE.
- IDLE: if FIFO non-empty and shape_done = 1, pop the head. Register draw_x, draw_y and start_address = sprite*SPRITE_WORDS (15-bit, no overflow by parameter rule). Go to LOAD. Otherwise stay in IDLE.
- LOAD: one cycle of settled operands -> START.
- START: start = 1 for exactly this cycle -> WAIT_ACK; clear timeout counter.
- WAIT_ACK: shape_done = 0 -> WAIT_DONE. Else increment counter; at ACK_TIMEOUT cycles set err_timeout and go to IDLE; request discarded, shapes_drawn unchanged.
- WAIT_DONE: shape_done = 1 -> IDLE, shapes_drawn += 1 (mod 256). Stay otherwise; no timeout here (a full draw is ~7200 cycles).
- draw_x, draw_y and start_address hold from LOAD until the next pop. The drawer samples them any time during its draw.
- Latency, empty FIFO: request accepted at edge N -> popped at N+1 -> LOAD N+2 -> start high in the cycle after edge N+3.
- Back-to-back requests: the next pop occurs on the first IDLE cycle, minimum 1 idle cycle between draws.
- err_timeout clears only on reset.
- A push during any state, including simultaneous push and pop in IDLE, is accepted if not full.

Decomposition:
- Shared package: FSM state encoding constants; SPRITE_WORDS default; origin widths (X_W = 8, Y_W = 7); ROM address width (15).
- Sub-module draw_req_fifo: synchronous FIFO, parameterised width/depth, push/pop/full/empty, async active-low reset. The sequencer FSM lives in the top module.

Test Plan:
- Reset then single request (x=10, y=20, sprite=2): start pulses once 3 cycles after acceptance, start_address = 7200. Drawer model drops shape_done next cycle and raises it 7200 cycles later -> shapes_drawn = 1, busy falls.
- Five requests pushed in consecutive cycles with FIFO_DEPTH=4: req_ready falls after the fourth and the fifth is dropped. Exactly 4 start pulses with the pushed operands in order; shapes_drawn = 4.
- shape_done held high after start: err_timeout sets exactly ACK_TIMEOUT cycles after the start pulse and FSM returns to IDLE. The next queued request still issues; err_timeout stays 1.
- shape_done low at request time (drawer busy elsewhere): no pop until shape_done rises, then LOAD/START proceed normally.
- resetn asserted mid-WAIT_DONE with 2 entries queued: all outputs return to reset values immediately (async); no start after release until new requests arrive.
- 256 completed draws -> shapes_drawn wraps to 0; sprite=3 -> start_address = 10800.

Source files
------------

// File: rtl/sprite_draw_sequencer_pkg.sv
// Shared widths, state encoding and ROM base helper for the sprite draw sequencer.
package sprite_draw_sequencer_pkg;

    localparam int X_W              = 8;
    localparam int Y_W              = 7;
    localparam int ADDR_W           = 15;
    localparam int SPRITE_WORDS_DEF = 3600;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } seq_state_t;

    // Sprite ROM base; parameter limits guarantee the product fits ADDR_W.
    function automatic logic [ADDR_W-1:0] sprite_base(input int unsigned idx,
                                                       input int unsigned words);
        return ADDR_W'(idx * words);
    endfunction

endpackage

// File: rtl/sprite_draw_sequencer_if.sv
// Request and drawer-side signals of the sprite draw sequencer.
interface sprite_draw_sequencer_if #(parameter int SPRITE_BITS = 2);
    import sprite_draw_sequencer_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [X_W-1:0]         req_x;
    logic [Y_W-1:0]         req_y;
    logic [SPRITE_BITS-1:0] req_sprite;
    logic [X_W-1:0]         draw_x;
    logic [Y_W-1:0]         draw_y;
    logic [ADDR_W-1:0]      start_address;
    logic                   start;
    logic                   shape_done;
    logic                   busy;
    logic                   err_timeout;
    logic [7:0]             shapes_drawn;

    modport master (
        input  req_valid, req_x, req_y, req_sprite, shape_done,
        output req_ready, draw_x, draw_y, start_address, start,
               busy, err_timeout, shapes_drawn
    );

    modport slave (
        output req_valid, req_x, req_y, req_sprite, shape_done,
        input  req_ready, draw_x, draw_y, start_address, start,
               busy, err_timeout, shapes_drawn
    );

endinterface

// File: rtl/sprite_draw_sequencer_draw_req_fifo.sv
// Generic synchronous FIFO, head visible combinationally; a pushed word is poppable next cycle.
// Push ignored when full, pop ignored when empty; full/empty are pure state, no same-cycle pass-through.
module draw_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Queues sprite draw requests and hands each to the shape drawer: operands, start pulse, busy/done wait.
// Start pulses 3 cycles after acceptance into an empty queue; requests arriving while full are dropped.
module sprite_draw_sequencer
    import sprite_draw_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SPRITE_BITS  = 2,
    parameter int SPRITE_WORDS = SPRITE_WORDS_DEF,
    parameter int ACK_TIMEOUT  = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    sprite_draw_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef struct packed {
        logic [X_W-1:0]         x;
        logic [Y_W-1:0]         y;
        logic [SPRITE_BITS-1:0] sprite;
    } req_t;

    req_t              push_req;
    req_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    seq_state_t        state;
    logic [CNT_W-1:0]  ack_cnt;
    logic [X_W-1:0]    draw_x_q;
    logic [Y_W-1:0]    draw_y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start_q;
    logic              busy_q;
    logic              err_q;
    logic [7:0]        drawn_q;

    assign push_req = '{x: bus.req_x, y: bus.req_y, sprite: bus.req_sprite};
    assign pop      = (state == ST_IDLE) && !fifo_empty && bus.shape_done;

    draw_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push     (bus.req_valid),
        .push_dat (push_req),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // start is registered out of START, so the drawer sees it during the first WAIT_ACK cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            ack_cnt  <= '0;
            draw_x_q <= '0;
            draw_y_q <= '0;
            addr_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            drawn_q  <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        draw_x_q <= head.x;
                        draw_y_q <= head.y;
                        addr_q   <= sprite_base(32'(head.sprite), SPRITE_WORDS);
                        state    <= ST_LOAD;
                        busy_q   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_START;
                end
                ST_START: begin
                    start_q <= 1'b1;
                    ack_cnt <= '0;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!bus.shape_done) begin
                        state <= ST_WAIT_DONE;
                    end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        // Drawer never went busy: drop this request and move on.
                        err_q  <= 1'b1;
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.shape_done) begin
                        drawn_q <= drawn_q + 8'd1;
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = !fifo_full;
    assign bus.draw_x        = draw_x_q;
    assign bus.draw_y        = draw_y_q;
    assign bus.start_address = addr_q;
    assign bus.start         = start_q;
    assign bus.busy          = busy_q;
    assign bus.err_timeout   = err_q;
    assign bus.shapes_drawn  = drawn_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench for sprite_draw_sequencer with a behavioural drawer and an operand scoreboard.
module tb_sprite_draw_sequencer;
    import sprite_draw_sequencer_pkg::*;

    localparam int SB    = 2;
    localparam int DEPTH = 4;
    localparam int WORDS = 3600;
    localparam int ACKT  = 8;

    typedef struct {
        int x;
        int y;
        int addr;
    } exp_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    sprite_draw_sequencer_if #(.SPRITE_BITS(SB)) bus ();

    sprite_draw_sequencer #(
        .FIFO_DEPTH   (DEPTH),
        .SPRITE_BITS  (SB),
        .SPRITE_WORDS (WORDS),
        .ACK_TIMEOUT  (ACKT)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int   checks    = 0;
    int   errors    = 0;
    int   start_cnt = 0;
    exp_t sb[$];

    // Drawer model: goes busy the cycle after it sees start, idle again drw_len cycles later.
    int drw_len    = 5;
    bit drw_hold   = 1'b0;
    bit drw_ignore = 1'b0;
    bit drw_active;
    int drw_left;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drw_active <= 1'b0;
            drw_left   <= 0;
        end else if (bus.start === 1'b1 && !drw_ignore) begin
            drw_active <= 1'b1;
            drw_left   <= drw_len;
        end else if (drw_active) begin
            if (drw_left <= 1) drw_active <= 1'b0;
            else               drw_left   <= drw_left - 1;
        end
    end

    assign bus.shape_done = !drw_active && !drw_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (resetn && bus.start === 1'b1) begin
            start_cnt++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL start_unexpected observed=start pulse expected=no pulse");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("draw_x", 32'(bus.draw_x), e.x);
                chk("draw_y", 32'(bus.draw_y), e.y);
                chk("start_address", 32'(bus.start_address), e.addr);
            end
        end
    end

    // Called just after a negedge; drives for one cycle and returns at the next negedge.
    task automatic push(input int x, input int y, input int s, input bit exp_acc);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_acc));
        bus.req_valid  = 1'b1;
        bus.req_x      = 8'(x);
        bus.req_y      = 7'(y);
        bus.req_sprite = 2'(s);
        if (exp_acc) sb.push_back('{x: x, y: y, addr: s * WORDS});
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drawn(input int target, input int budget, input string tag);
        int n = 0;
        while (bus.shapes_drawn !== 8'(target) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(bus.shapes_drawn), target);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n = 0;
        while (bus.start !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(bus.start), 1);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_busy"},   32'(bus.busy), 0);
        chk({pfx, "_start"},  32'(bus.start), 0);
        chk({pfx, "_err"},    32'(bus.err_timeout), 0);
        chk({pfx, "_drawn"},  32'(bus.shapes_drawn), 0);
        chk({pfx, "_x"},      32'(bus.draw_x), 0);
        chk({pfx, "_y"},      32'(bus.draw_y), 0);
        chk({pfx, "_addr"},   32'(bus.start_address), 0);
        chk({pfx, "_ready"},  32'(bus.req_ready), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s0;
        bus.req_valid  = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_sprite = '0;

        // Reset values
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_state("rst");
        resetn = 1'b1;
        @(negedge clock);

        // Single request, exact start latency, full-length draw
        drw_len = 7200;
        push(10, 20, 2, 1'b1);
        chk("lat_n0_start", 32'(bus.start), 0);
        @(negedge clock);
        chk("lat_n1_start", 32'(bus.start), 0);
        @(negedge clock);
        chk("lat_n2_start", 32'(bus.start), 0);
        chk("lat_n2_busy", 32'(bus.busy), 1);
        @(negedge clock);
        chk("lat_n3_start", 32'(bus.start), 1);
        chk("addr_sprite2", 32'(bus.start_address), 7200);
        @(negedge clock);
        chk("start_one_cycle", 32'(bus.start), 0);
        wait_drawn(1, 7400, "drawn_single");
        chk("busy_after_single", 32'(bus.busy), 0);

        // Drawer busy elsewhere: fill queue, fifth request dropped, then drain in order
        drw_len  = 5;
        drw_hold = 1'b1;
        push(1, 2, 0, 1'b1);
        push(3, 4, 1, 1'b1);
        push(5, 6, 2, 1'b1);
        push(7, 8, 3, 1'b1);
        push(9, 10, 1, 1'b0);
        repeat (3) @(negedge clock);
        chk("no_pop_while_done_low", 32'(bus.busy), 0);
        chk("ready_low_full", 32'(bus.req_ready), 0);
        s0 = start_cnt;
        drw_hold = 1'b0;
        wait_drawn(5, 300, "drawn_burst");
        chk("burst_starts", 32'(start_cnt - s0), 4);
        chk("burst_sb_empty", 32'(sb.size()), 0);
        chk("ready_after_drain", 32'(bus.req_ready), 1);

        // Drawer ignores start: timeout after ACK_TIMEOUT cycles, next request still issues
        drw_ignore = 1'b1;
        push(11, 12, 1, 1'b1);
        push(13, 14, 3, 1'b1);
        wait_start(20, "to_start_seen");
        @(negedge clock);
        drw_ignore = 1'b0;
        chk("to_err_c1", 32'(bus.err_timeout), 0);
        for (int k = 2; k < ACKT; k++) begin
            @(negedge clock);
            chk("to_err_early", 32'(bus.err_timeout), 0);
        end
        @(negedge clock);
        chk("to_err_set", 32'(bus.err_timeout), 1);
        chk("to_busy_idle", 32'(bus.busy), 0);
        chk("to_drawn_same", 32'(bus.shapes_drawn), 5);
        wait_drawn(6, 200, "drawn_after_to");
        chk("to_err_sticky", 32'(bus.err_timeout), 1);

        // Async reset in the middle of a draw with two requests queued
        drw_len = 60;
        push(20, 30, 0, 1'b1);
        push(21, 31, 1, 1'b1);
        push(22, 32, 2, 1'b1);
        wait_start(20, "rst_mid_start");
        repeat (5) @(negedge clock);
        chk("mid_busy", 32'(bus.busy), 1);
        chk("mid_drawer_busy", 32'(bus.shape_done), 0);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_state("arst");
        sb.delete();
        @(negedge clock);
        resetn = 1'b1;
        s0 = start_cnt;
        repeat (20) @(negedge clock);
        chk("no_start_after_rst", 32'(start_cnt - s0), 0);
        chk("idle_after_rst", 32'(bus.busy), 0);

        // 256 draws of sprite 3 wrap the completion counter
        drw_len = 2;
        s0 = start_cnt;
        for (int i = 0; i < 256; i++) begin
            wait_ready(50);
            push(i % 256, i % 128, 3, 1'b1);
        end
        wait_drawn(255, 4000, "drawn_255");
        wait_drawn(0, 100, "drawn_wrap");
        chk("wrap_starts", 32'(start_cnt - s0), 256);
        chk("addr_sprite3", 32'(bus.start_address), 10800);
        chk("wrap_sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
